// File: rtl/imm_gen_pipe_pkg.sv
// Shared codes for the IF/ID immediate generator.
// Format selects, opcodes and skid buffer state encoding.
package imm_gen_pipe_pkg;

  localparam logic [2:0] IMM_FMT_U   = 3'b000;
  localparam logic [2:0] IMM_FMT_I   = 3'b001;
  localparam logic [2:0] IMM_FMT_S   = 3'b010;
  localparam logic [2:0] IMM_FMT_B   = 3'b011;
  localparam logic [2:0] IMM_FMT_J   = 3'b100;
  localparam logic [2:0] IMM_FMT_Z   = 3'b101;
  localparam logic [2:0] IMM_FMT_ILL = 3'b111;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational format-to-immediate expander.
// Z (CSR zimm) is only legal when IMM_GEN_ZIMM_EN is defined.
module imm_gen_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0]      raw;
  logic [XLEN+31:0] wide;
  logic             zext;
  logic             unused;

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    zext    = 1'b0;
    unique case (fmt)
      IMM_FMT_I: raw = {{20{inst[31]}}, inst[31:20]};
      IMM_FMT_S: raw = {{20{inst[31]}}, inst[31:25],
                        inst[11:7]};
      IMM_FMT_B: raw = {{20{inst[31]}}, inst[7],
                        inst[30:25], inst[11:8], 1'b0};
      IMM_FMT_J: raw = {{12{inst[31]}}, inst[19:12],
                        inst[20], inst[30:21], 1'b0};
      IMM_FMT_U: raw = {inst[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
      IMM_FMT_Z: begin
        raw  = {27'b0, inst[19:15]};
        zext = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
    // every format is a 32-bit value widened to XLEN
    wide = {{XLEN{raw[31] & ~zext}}, raw};
    imm  = wide[XLEN-1:0];
  end

  assign unused = ^{inst[6:0], wide[XLEN+31:XLEN]};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer.
// Optional CSR zimm support via IMM_GEN_ZIMM_EN.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  skid_state_e     state, state_n;
  logic [2:0]      sel_fmt;
  logic [6:0]      opc;
  logic [XLEN-1:0] new_imm;
  logic            new_ill;
  logic            in_fire, out_fire;

  logic [XLEN-1:0] head_imm, tail_imm;
  logic [2:0]      head_fmt, tail_fmt;
  logic            head_ill, tail_ill;

  assign opc = inst[6:0];

  always_comb begin
    sel_fmt = imm_sel;
    if (AUTO_DECODE != 0) begin
      unique case (1'b1)
        (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
        (opc == OPC_JALR):   sel_fmt = IMM_FMT_I;
        (opc == OPC_STORE):  sel_fmt = IMM_FMT_S;
        (opc == OPC_BRANCH): sel_fmt = IMM_FMT_B;
        (opc == OPC_JAL):    sel_fmt = IMM_FMT_J;
        (opc == OPC_LUI) ||
        (opc == OPC_AUIPC):  sel_fmt = IMM_FMT_U;
        (opc == OPC_SYSTEM): sel_fmt = IMM_FMT_Z;
        default:             sel_fmt = IMM_FMT_ILL;
      endcase
    end
  end

  imm_gen_comb #(.XLEN(XLEN)) u_comb (
    .inst    (inst),
    .fmt     (sel_fmt),
    .imm     (new_imm),
    .illegal (new_ill)
  );

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign imm       = head_imm;
  assign fmt       = head_fmt;
  assign illegal   = head_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SKID_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SKID_EMPTY: if (in_fire) state_n = SKID_ONE;
      SKID_ONE: begin
        if (in_fire && !out_fire)      state_n = SKID_FULL;
        else if (!in_fire && out_fire) state_n = SKID_EMPTY;
      end
      SKID_FULL: if (out_fire) state_n = SKID_ONE;
      default:   state_n = SKID_EMPTY;
    endcase
    if (flush) state_n = SKID_EMPTY;
  end

  // head loads fresh data when it is (or becomes) the only entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_imm <= '0;
      head_fmt <= '0;
      head_ill <= 1'b0;
      tail_imm <= '0;
      tail_fmt <= '0;
      tail_ill <= 1'b0;
    end else if (!flush) begin
      if (in_fire && ((state == SKID_EMPTY) ||
          (state == SKID_ONE && out_fire))) begin
        head_imm <= new_imm;
        head_fmt <= sel_fmt;
        head_ill <= new_ill;
      end else if (state == SKID_FULL && out_fire) begin
        head_imm <= tail_imm;
        head_fmt <= tail_fmt;
        head_ill <= tail_ill;
      end
      if (in_fire && state == SKID_ONE && !out_fire) begin
        tail_imm <= new_imm;
        tail_fmt <= sel_fmt;
        tail_ill <= new_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: queue model plus directed literal vectors.
// Second instance covers AUTO_DECODE=1 with XLEN=64.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  imm_sel = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;
  logic [2:0]  fmt;

  logic        in_ready2, out_valid2, illegal2;
  logic [63:0] imm2;
  logic [2:0]  fmt2;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .imm_sel(imm_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .inst(inst), .imm_sel(imm_sel),
    .out_valid(out_valid2), .out_ready(out_ready),
    .imm(imm2), .fmt(fmt2), .illegal(illegal2)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      npass++;
  endtask

  function automatic exp_t model(logic [31:0] w,
                                 logic [2:0] s);
    exp_t e;
    int   sw;
    sw    = int'(w);
    e.fmt = s;
    e.ill = 1'b0;
    e.imm = '0;
    case (s)
      3'd1: e.imm = 32'(sw >>> 20);
      3'd2: e.imm = 32'(((sw >>> 25) <<< 5) + int'(w[11:7]));
      3'd3: e.imm = 32'(((sw >>> 31) <<< 12)
                      + (int'(w[7]) << 11)
                      + (int'(w[30:25]) << 5)
                      + (int'(w[11:8]) << 1));
      3'd4: e.imm = 32'(((sw >>> 31) <<< 20)
                      + (int'(w[19:12]) << 12)
                      + (int'(w[20]) << 11)
                      + (int'(w[30:21]) << 1));
      3'd0: e.imm = w & 32'hFFFF_F000;
`ifdef IMM_GEN_ZIMM_EN
      3'd5: e.imm = (w >> 15) & 32'h1F;
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  bit pop, push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(model(inst, imm_sel));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("m_imm", 64'(imm), 64'(q[0].imm));
        chk("m_fmt", 64'(fmt), 64'(q[0].fmt));
        chk("m_ill", 64'(illegal), 64'(q[0].ill));
      end
    end
  end

  logic [31:0] vi [6];
  logic [2:0]  vs [6];
  logic [31:0] ve [6];
  logic [63:0] ve2 [6];
  logic [2:0]  vf2 [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vi[0] = 32'hFFF00093; vs[0] = 3'd1; ve[0] = 32'hFFFFFFFF;
    vi[1] = 32'hFE20AE23; vs[1] = 3'd2; ve[1] = 32'hFFFFFFFC;
    vi[2] = 32'h00000863; vs[2] = 3'd3; ve[2] = 32'h00000010;
    vi[3] = 32'hFF9FF06F; vs[3] = 3'd4; ve[3] = 32'hFFFFFFF8;
    vi[4] = 32'h123450B7; vs[4] = 3'd0; ve[4] = 32'h12345000;
    vi[5] = 32'h800000B7; vs[5] = 3'd0; ve[5] = 32'h80000000;
    ve2[0] = 64'hFFFFFFFFFFFFFFFF; vf2[0] = 3'd1;
    ve2[1] = 64'hFFFFFFFFFFFFFFFC; vf2[1] = 3'd2;
    ve2[2] = 64'h0000000000000010; vf2[2] = 3'd3;
    ve2[3] = 64'hFFFFFFFFFFFFFFF8; vf2[3] = 3'd4;
    ve2[4] = 64'h0000000012345000; vf2[4] = 3'd0;
    ve2[5] = 64'hFFFFFFFF80000000; vf2[5] = 3'd0;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_fmt", 64'(fmt), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst = vi[i]; imm_sel = vs[i]; in_valid = 1'b1;
      step();
      chk("fmt_valid", 64'(out_valid), 64'd1);
      chk("fmt_imm", 64'(imm), 64'(ve[i]));
      chk("auto_imm", imm2, ve2[i]);
      chk("auto_fmt", 64'(fmt2), 64'(vf2[i]));
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    inst = 32'hFFF00093; imm_sel = 3'd1; in_valid = 1'b1;
    step();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    inst = 32'h123450B7; imm_sel = 3'd0;
    step();
    in_valid = 1'b0;
    chk("bp_ready2", 64'(in_ready), 64'd0);
    chk("bp_headA", 64'(imm), 64'hFFFFFFFF);
    step();
    chk("bp_holdA", 64'(imm), 64'hFFFFFFFF);
    out_ready = 1'b1;
    step();
    chk("bp_B", 64'(imm), 64'h12345000);
    chk("bp_B_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_done", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    inst = 32'hFFF00093; imm_sel = 3'd1; in_valid = 1'b1;
    step();
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    inst = 32'h00500093; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_gone", 64'(out_valid), 64'd0);
    end

    inst = 32'h00000013; imm_sel = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_imm", 64'(imm), 64'd0);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_fmt", 64'(fmt), 64'd6);
    step();

    inst = 32'h000FD073; imm_sel = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("z_fmt", 64'(fmt), 64'd5);
    chk("z_auto_fmt", 64'(fmt2), 64'd5);
`ifdef IMM_GEN_ZIMM_EN
    chk("z_imm", 64'(imm), 64'h1F);
    chk("z_ill", 64'(illegal), 64'd0);
    chk("z_auto_imm", imm2, 64'h1F);
`else
    chk("z_imm", 64'(imm), 64'd0);
    chk("z_ill", 64'(illegal), 64'd1);
    chk("z_auto_ill", 64'(illegal2), 64'd1);
`endif
    step();

    inst = 32'hFFF00093; imm_sel = 3'd1; in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("ar_one", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async_valid", 64'(out_valid), 64'd0);
    chk("ar_async_imm", 64'(imm), 64'd0);
    chk("ar_async_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_after", 64'(out_valid), 64'd0);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the IF/ID boundary of the pipelined RV core.
- Accepts a fetched instruction and a format select (or decodes the format from the opcode), then produces the sign-extended immediate.
- Generalised in XLEN and in select mode.
- Holds results in a 2-entry skid buffer so ID stalls never drop or duplicate an immediate. Supports pipeline flush.

Parameters:
- XLEN, 32, output immediate width; legal values are 32 and 64; sign extension fills to XLEN.
- AUTO_DECODE, 0, 0 = format taken from imm_sel; 1 = format decoded from inst[6:0] and imm_sel ignored.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries (branch/jump redirect).
- in_valid  in  1  instruction presented.
- in_ready  out  1  buffer can accept this cycle.
- inst  in  32  full instruction word.
- imm_sel  in  3  format select: 000 U, 001 I, 010 S, 011 B, 100 J, 101 Z (optional), others illegal.
- out_valid  out  1  imm/fmt/illegal valid.
- out_ready  in  1  ID consumes this cycle.
- imm  out  XLEN  generated immediate.
- fmt  out  3  format actually used (the decoded or selected code).
- illegal  out  1  select/opcode had no immediate format; imm forced to 0.

Behaviour:
- Reset (async, rst_n=0): both buffer entries invalid. out_valid=0, imm=0, fmt=000, illegal=0, in_ready=1.
- Transfer rules: input fires when in_valid & in_ready; output fires when out_valid & out_ready.
- Latency is 1 cycle: a word accepted at edge N is visible at out_valid after edge N.
- Throughput is 1 per cycle while out_ready=1.
- Skid buffer states: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
- in_ready = (state != FULL); it is a registered function of state only and has no combinational path from out_ready.
- Output order is FIFO. Output comes from the head entry. The tail entry is promoted to head when the head is consumed.
- Transitions:
  - EMPTY + in fire -> ONE.
  - ONE + in fire + out fire -> ONE (the new entry becomes head).
  - ONE + in fire only -> FULL.
  - ONE + out fire only -> EMPTY.
  - FULL + out fire -> ONE (in cannot fire in FULL).
- Format arithmetic, with S = sign extension of inst[31] to XLEN:
  - I: S | inst[31:20].
  - S: S | inst[31:25] | inst[11:7].
  - B: S | inst[7] | inst[30:25] | inst[11:8] | 0.
  - J: S | inst[19:12] | inst[20] | inst[30:21] | 0. No extra shift is applied.
  - U: inst[31:12] | 12'b0, sign-extended above bit 31 when XLEN=64.
- Illegal select: imm=0, illegal=1, and the entry still flows through normally. It is never dropped.
- AUTO_DECODE=1 opcode-to-format map:
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - 0110111, 0010111 -> U.
  - 1110011 -> Z if enabled, else illegal.
  - All other opcodes -> illegal.
- Flush: at the next edge all entries are invalidated; out_valid=0 and in_ready=1. An input presented in the same cycle as flush is discarded. flush has priority over in fire and out fire.
- Reset asserted mid-stream: entries are lost immediately. No partial output appears after rst_n rises.
- Data registers are captured only on in fire or on a shift. imm/fmt hold their value while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: select 101, and opcode 1110011 under AUTO_DECODE, produce the CSR zimm, i.e. inst[19:15] zero-extended to XLEN, with illegal=0.
- Undefined: select 101 and opcode 1110011 are treated as illegal (imm=0, illegal=1).

Decomposition:
- Shared package holds:
  - IMM_FMT_U/I/S/B/J/Z 3-bit codes.
  - OPC_* 7-bit opcode constants.
  - Skid state encoding (EMPTY/ONE/FULL).
- One sub-module: imm_gen_comb. It is a purely combinational format-to-immediate expander (inst, fmt -> imm, illegal), parameterised by XLEN.
- The top contains the select/decode mux and the skid buffer.

Test Plan:
- Formats, XLEN=32, out_ready=1:
  - inst 0xFFF00093 sel I -> imm 0xFFFFFFFF.
  - 0xFE20AE23 sel S -> 0xFFFFFFFC.
  - 0x00000863 sel B -> 0x00000010.
  - 0xFF9FF06F sel J -> 0xFFFFFFF8.
  - 0x123450B7 sel U -> 0x12345000.
  - Each appears exactly 1 cycle after its accept.
- Backpressure: out_ready=0, push A=0xFFF00093 and B=0x123450B7. in_ready falls after the 2nd accept. Raise out_ready; outputs A then B are observed, with no loss and no duplicate.
- Flush while FULL: asserting flush with in_valid=1 gives out_valid=0 next cycle and in_ready=1. The concurrently presented word never appears.
- Illegal: sel 110 with inst 0x00000013 -> imm 0, illegal=1, fmt 110, out_valid=1.
- AUTO_DECODE=1, XLEN=64: inst 0xFF9FF06F -> fmt J, imm 0xFFFFFFFFFFFFFFF8. inst 0x800000B7 -> imm 0xFFFFFFFF80000000.
- IMM_GEN_ZIMM_EN: sel Z with inst 0x000FD073 (zimm=31) -> imm 0x1F. With the macro undefined, the same stimulus gives illegal=1 and imm 0.
- Async reset: drop rst_n mid-cycle while ONE. out_valid=0 immediately, without waiting for a clk edge.
